// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Ordered multi-channel reset release with programmable hold/gap,
//            software re-sequencing and a completed-sequence counter.
//            Optional watchdog enabled by defining RST_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int CHANNELS    = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                CtrlRst,
    input  logic                SoftRstReq,
    input  logic                Kick,
    output logic [CHANNELS-1:0] ChanRst,
    output logic                Busy,
    output logic                Done,
    output logic [7:0]          SeqCount,
    output logic                WdogFired
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_GAP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       c_LAST_GAP_IDX = 3'((CHANNELS > 1) ? CHANNELS - 2 : 0);

    logic [1:0]          r_sync;
    logic                w_rst_int;
    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [2:0]          r_idx,     w_idx_nxt;
    logic [CHANNELS-1:0] r_chan,    w_chan_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic [7:0]          r_seq_cnt, w_seq_cnt_nxt;
    logic                w_wdog_fire;
    logic                w_restart;

    // Internal reset asserts with CtrlRst and releases two clocks after it falls.
    always_ff @(posedge CLK or posedge CtrlRst) begin
        if (CtrlRst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], 1'b0};
        end
    end

    assign w_rst_int = r_sync[1];

    always_ff @(posedge CLK or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_chan    <= '1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_seq_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_chan    <= w_chan_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_seq_cnt <= w_seq_cnt_nxt;
        end
    end

    assign w_restart = SoftRstReq | w_wdog_fire;

    // Channels release by shifting zeros in from bit 0, which keeps the order strict.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_chan_nxt  = r_chan;
        if (w_restart) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_chan_nxt  = '1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_chan_nxt  = r_chan << 1;
                        w_state_nxt = (CHANNELS == 1) ? S_DONE : S_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_cnt_nxt  = '0;
                        w_chan_nxt = r_chan << 1;
                        w_idx_nxt  = r_idx + 1'b1;
                        if (r_idx == c_LAST_GAP_IDX) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_chan_nxt  = '1;
                end
            endcase
        end
    end

    always_comb begin
        w_busy_nxt    = |w_chan_nxt;
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_seq_cnt_nxt = r_seq_cnt;
        if ((w_state_nxt == S_DONE) && (r_state != S_DONE) && (r_seq_cnt != 8'hFF)) begin
            w_seq_cnt_nxt = r_seq_cnt + 8'd1;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    logic [CNT_W-1:0] r_wdog,  w_wdog_nxt;
    logic [CNT_W-1:0] w_wdog_inc;
    logic             r_wdog_fired;

    // The edge on which the count would reach WDOG_CYCLES-1 is the timeout edge.
    always_comb begin
        w_wdog_inc  = r_wdog + 1'b1;
        w_wdog_fire = (r_state == S_DONE) && !Kick && (w_wdog_inc == CNT_W'(WDOG_CYCLES - 1));
        w_wdog_nxt  = w_wdog_inc;
        if ((r_state != S_DONE) || (w_state_nxt != S_DONE) || Kick) begin
            w_wdog_nxt = '0;
        end
    end

    always_ff @(posedge CLK or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_wdog       <= '0;
            r_wdog_fired <= 1'b0;
        end else begin
            r_wdog       <= w_wdog_nxt;
            r_wdog_fired <= r_wdog_fired | w_wdog_fire;
        end
    end

    assign WdogFired = r_wdog_fired;
`else
    assign w_wdog_fire = 1'b0;
    assign WdogFired   = 1'b0;
`endif

    assign ChanRst  = r_chan;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign SeqCount = r_seq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer; three configurations are
//            compared against an edge-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       CLK;
    logic       CtrlRst;
    logic       SoftRstReq;
    logic       Kick;

    logic [2:0] chan0;
    logic [0:0] chan1;
    logic [3:0] chan2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [7:0] seq0, seq1, seq2;
    logic       wf0, wf1, wf2;

    reset_sequencer u0 (
        .CLK(CLK), .CtrlRst(CtrlRst), .SoftRstReq(SoftRstReq), .Kick(Kick),
        .ChanRst(chan0), .Busy(busy0), .Done(done0), .SeqCount(seq0), .WdogFired(wf0)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1)) u1 (
        .CLK(CLK), .CtrlRst(CtrlRst), .SoftRstReq(SoftRstReq), .Kick(Kick),
        .ChanRst(chan1), .Busy(busy1), .Done(done1), .SeqCount(seq1), .WdogFired(wf1)
    );

    reset_sequencer #(.CHANNELS(4), .GAP_CYCLES(3)) u2 (
        .CLK(CLK), .CtrlRst(CtrlRst), .SoftRstReq(SoftRstReq), .Kick(Kick),
        .ChanRst(chan2), .Busy(busy2), .Done(done2), .SeqCount(seq2), .WdogFired(wf2)
    );

    logic [7:0] a_chan [3];
    logic       a_busy [3];
    logic       a_done [3];
    logic [7:0] a_seq  [3];
    logic       a_wf   [3];

    assign a_chan[0] = {5'd0, chan0};
    assign a_chan[1] = {7'd0, chan1};
    assign a_chan[2] = {4'd0, chan2};
    assign a_busy[0] = busy0;  assign a_busy[1] = busy1;  assign a_busy[2] = busy2;
    assign a_done[0] = done0;  assign a_done[1] = done1;  assign a_done[2] = done2;
    assign a_seq[0]  = seq0;   assign a_seq[1]  = seq1;   assign a_seq[2]  = seq2;
    assign a_wf[0]   = wf0;    assign a_wf[1]   = wf1;    assign a_wf[2]   = wf2;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int P_CH   [3] = '{3, 1, 4};
    int P_HOLD [3] = '{4, 1, 4};
    int P_GAP  [3] = '{2, 2, 3};
    int WDOG = 16;

    // Model: m_k counts functional edges since the sequence (re)started.
    int m_k [3];
    int m_seq [3];
    int m_wd [3];
    bit m_wf [3];
    int m_sync;

    int nchk;
    int npass;
    int edge_no;

    function automatic int n_rel(int i);
        int r;
        if (m_k[i] < P_HOLD[i]) return 0;
        r = 1 + (m_k[i] - P_HOLD[i]) / P_GAP[i];
        return (r > P_CH[i]) ? P_CH[i] : r;
    endfunction

    function automatic logic [7:0] exp_chan(int i);
        int v;
        v = (32'hFF << n_rel(i)) & ((1 << P_CH[i]) - 1);
        return v[7:0];
    endfunction

    function automatic logic exp_done(int i);
        return n_rel(i) == P_CH[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_k[i] = 0; m_seq[i] = 0; m_wd[i] = 0; m_wf[i] = 1'b0;
        end
        m_sync = 2;
    endtask

    task automatic tick();
        bit done_i;
        bit fire;
        @(posedge CLK);
        edge_no++;
        if (CtrlRst) begin
            model_reset();
        end else if (m_sync > 0) begin
            m_sync--;
        end else begin
            for (int i = 0; i < 3; i++) begin
                done_i = exp_done(i);
                fire   = 1'b0;
`ifdef RST_SEQ_WDOG_EN
                if (done_i) begin
                    if (Kick) m_wd[i] = 0;
                    else begin
                        m_wd[i]++;
                        if (m_wd[i] == WDOG - 1) begin
                            fire = 1'b1;
                            m_wf[i] = 1'b1;
                        end
                    end
                end
`endif
                if (SoftRstReq || fire) begin
                    m_k[i] = 0;
                end else if (!done_i) begin
                    m_k[i]++;
                    if (exp_done(i)) begin
                        if (m_seq[i] < 255) m_seq[i]++;
                        m_wd[i] = 0;
                    end
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [2:0] want;
        CtrlRst = 1'b1; SoftRstReq = 1'b0; Kick = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (a_chan[i] !== 8'((1 << P_CH[i]) - 1) || a_busy[i] !== 1'b1 || a_done[i] !== 1'b0
                || a_seq[i] !== 8'd0 || a_wf[i] !== 1'b0)
                $display("FAIL reset_vals u%0d: got chan=%h busy=%b done=%b seq=%0d wf=%b", i,
                         a_chan[i], a_busy[i], a_done[i], a_seq[i], a_wf[i]);
            else npass++;
        end
        CtrlRst = 1'b0;
        edge_no = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            want = (e < 6) ? 3'b111 : (e < 8) ? 3'b110 : (e < 10) ? 3'b100 : 3'b000;
            nchk++;
            if (chan0 !== want)
                $display("FAIL powerup_chan edge %0d: got %b want %b", e, chan0, want);
            else npass++;
            if (e == 3) begin
                nchk++;
                if (chan1 !== 1'b0 || done1 !== 1'b1)
                    $display("FAIL single_chan edge 3: got chan=%b done=%b want 0/1", chan1, done1);
                else npass++;
            end
            if (e == 10) begin
                nchk++;
                if (done0 !== 1'b1 || busy0 !== 1'b0 || seq0 !== 8'd1)
                    $display("FAIL powerup_done edge 10: got done=%b busy=%b seq=%0d want 1/0/1",
                             done0, busy0, seq0);
                else npass++;
            end
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (a_chan[i] !== exp_chan(i) || a_busy[i] !== !exp_done(i) || a_done[i] !== exp_done(i)
                    || a_seq[i] !== 8'(m_seq[i]) || a_wf[i] !== m_wf[i])
                    $display("FAIL powerup_model u%0d edge %0d: got chan=%h done=%b seq=%0d want chan=%h done=%b seq=%0d",
                             i, e, a_chan[i], a_done[i], a_seq[i], exp_chan(i), exp_done(i), m_seq[i]);
                else npass++;
            end
        end
    endtask

    task automatic test_soft_from_done();
        logic [2:0] want;
        repeat (5) tick();
        SoftRstReq = 1'b1;
        tick();
        SoftRstReq = 1'b0;
        nchk++;
        if (chan0 !== 3'b111 || done0 !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL soft_assert: got chan=%b done=%b busy=%b want 111/0/1", chan0, done0, busy0);
        else npass++;
        for (int d = 1; d <= 8; d++) begin
            tick();
            want = (d < 4) ? 3'b111 : (d < 6) ? 3'b110 : (d < 8) ? 3'b100 : 3'b000;
            nchk++;
            if (chan0 !== want)
                $display("FAIL soft_chan e+%0d: got %b want %b", d, chan0, want);
            else npass++;
        end
        nchk++;
        if (seq0 !== 8'd2 || done0 !== 1'b1)
            $display("FAIL soft_seqcount: got seq=%0d done=%b want 2/1", seq0, done0);
        else npass++;
    endtask

    task automatic test_async_and_abort();
        logic [2:0] want;
        SoftRstReq = 1'b1;
        tick();
        SoftRstReq = 1'b0;
        repeat (6) tick();
        #2 CtrlRst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (a_chan[i] !== 8'((1 << P_CH[i]) - 1) || a_done[i] !== 1'b0 || a_seq[i] !== 8'd0)
                $display("FAIL async_reset u%0d: got chan=%h done=%b seq=%0d want all-ones/0/0",
                         i, a_chan[i], a_done[i], a_seq[i]);
            else npass++;
        end
        #1 CtrlRst = 1'b0;
        model_reset();
        edge_no = 0;
        for (int e = 1; e <= 15; e++) begin
            SoftRstReq = (e == 7);
            tick();
            if (e < 7) want = (e < 6) ? 3'b111 : 3'b110;
            else       want = (e < 11) ? 3'b111 : (e < 13) ? 3'b110 : (e < 15) ? 3'b100 : 3'b000;
            nchk++;
            if (chan0 !== want)
                $display("FAIL abort_chan edge %0d: got %b want %b", e, chan0, want);
            else npass++;
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (a_chan[i] !== exp_chan(i) || a_done[i] !== exp_done(i) || a_seq[i] !== 8'(m_seq[i]))
                    $display("FAIL abort_model u%0d edge %0d: got chan=%h done=%b seq=%0d want chan=%h done=%b seq=%0d",
                             i, e, a_chan[i], a_done[i], a_seq[i], exp_chan(i), exp_done(i), m_seq[i]);
                else npass++;
            end
        end
        SoftRstReq = 1'b0;
        nchk++;
        if (seq0 !== 8'd1)
            $display("FAIL abort_seqcount: got %0d want 1", seq0);
        else npass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            SoftRstReq = ($urandom_range(0, 39) == 0);
            Kick       = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 CtrlRst = 1'b1;
                #2 CtrlRst = 1'b0;
                model_reset();
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (a_chan[i] !== exp_chan(i) || a_busy[i] !== !exp_done(i) || a_done[i] !== exp_done(i)
                    || a_seq[i] !== 8'(m_seq[i]) || a_wf[i] !== m_wf[i])
                    $display("FAIL random_model u%0d step %0d: got chan=%h busy=%b done=%b seq=%0d wf=%b want chan=%h done=%b seq=%0d wf=%b",
                             i, n, a_chan[i], a_busy[i], a_done[i], a_seq[i], a_wf[i],
                             exp_chan(i), exp_done(i), m_seq[i], m_wf[i]);
                else npass++;
            end
        end
        SoftRstReq = 1'b0;
        Kick = 1'b0;
    endtask

    task automatic test_wdog();
        int t0;
        int budget;
        SoftRstReq = 1'b0; Kick = 1'b0;
        budget = 0;
        while (done0 !== 1'b1 && budget < 40) begin tick(); budget++; end
        nchk++;
        if (done0 !== 1'b1) $display("FAIL wdog_wait_done: timed out, done=%b", done0);
        else npass++;
        t0 = edge_no;
`ifdef RST_SEQ_WDOG_EN
        budget = 0;
        while (chan0 === 3'b000 && budget < 40) begin tick(); budget++; end
        nchk++;
        if (edge_no - t0 != 15 || wf0 !== 1'b1)
            $display("FAIL wdog_fire: got delay=%0d wf=%b want 15/1", edge_no - t0, wf0);
        else npass++;
        budget = 0;
        while (done0 !== 1'b1 && budget < 40) begin tick(); budget++; end
        nchk++;
        if (done0 !== 1'b1 || wf0 !== 1'b1)
            $display("FAIL wdog_sticky: got done=%b wf=%b want 1/1", done0, wf0);
        else npass++;
        for (int n = 0; n < 60; n++) begin
            Kick = (n % 10 == 0);
            tick();
            nchk++;
            if (chan0 !== 3'b000 || a_chan[0] !== exp_chan(0))
                $display("FAIL wdog_kick step %0d: got chan=%b want 000", n, chan0);
            else npass++;
        end
        Kick = 1'b0;
`else
        repeat (40) tick();
        nchk++;
        if (chan0 !== 3'b000 || wf0 !== 1'b0 || edge_no - t0 != 40)
            $display("FAIL no_wdog: got chan=%b wf=%b want 000/0", chan0, wf0);
        else npass++;
`endif
    endtask

    initial begin
        nchk = 0; npass = 0; edge_no = 0;
        CtrlRst = 1'b1; SoftRstReq = 1'b0; Kick = 1'b0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_soft_from_done();
        test_async_and_abort();
        test_random();
        test_wdog();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
